// File: rtl/aurora_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the Aurora AXI-Stream TX port.
// Each granted packet gets a header word {tag, source, sequence}; overlong packets are cut.
module aurora_tx_arbiter #(
    parameter int         NUM_PORTS = 4,
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] HDR_TAG   = 8'hC3
) (
    input  logic                    auUserClk,
    input  logic                    resetN,
    input  logic [32*NUM_PORTS-1:0] sTdata,
    input  logic [NUM_PORTS-1:0]    sTlast,
    input  logic [NUM_PORTS-1:0]    sTvalid,
    output logic [NUM_PORTS-1:0]    sTready,
    output logic [31:0]             mTdata,
    output logic                    mTlast,
    output logic                    mTvalid,
    input  logic                    mTready,
    output logic [2:0]              grantIdx,
    output logic                    busy,
    output logic [15:0]             truncCount
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  last_grant, grant_nxt;
    logic        req_found;
    logic [15:0] pkt_seq, word_cnt;
    logic        o_free, xfer, at_limit;
    logic [255:0] data_pad;
    logic [7:0]   last_pad, valid_pad;
    logic [31:0]  grant_data;
    logic         grant_last, grant_valid;

    // Pad to the 8-port maximum so a 3-bit grant index always selects in range.
    assign data_pad    = 256'(sTdata);
    assign last_pad    = 8'(sTlast);
    assign valid_pad   = 8'(sTvalid);
    assign grant_data  = data_pad[{grantIdx, 5'b0} +: 32];
    assign grant_last  = last_pad[grantIdx];
    assign grant_valid = valid_pad[grantIdx];

    assign o_free   = !mTvalid || mTready;
    assign xfer     = (state == PAYLOAD) && grant_valid && o_free;
    assign at_limit = (word_cnt == 16'(MAX_WORDS - 1));

    always_comb begin
        int idx;
        idx       = 0;
        grant_nxt = last_grant;
        req_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!req_found && valid_pad[idx[2:0]]) begin
                req_found = 1'b1;
                grant_nxt = idx[2:0];
            end
        end
    end

    always_ff @(posedge auUserClk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_found) state_nxt = HEADER;
            HEADER:  if (o_free) state_nxt = PAYLOAD;
            PAYLOAD: if (xfer) begin
                         if (grant_last)    state_nxt = IDLE;
                         else if (at_limit) state_nxt = FLUSH;
                     end
            FLUSH:   if (grant_valid && grant_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FLUSH keeps the source draining regardless of downstream backpressure.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ready
        assign sTready[i] = (int'(grantIdx) == i) &&
                            (((state == PAYLOAD) && o_free) || (state == FLUSH));
    end
    assign busy = (state != IDLE);

    always_ff @(posedge auUserClk or negedge resetN) begin
        if (!resetN) begin
            last_grant <= 3'(NUM_PORTS - 1);
            grantIdx   <= 3'd0;
        end else if (state == IDLE && req_found) begin
            last_grant <= grant_nxt;
            grantIdx   <= grant_nxt;
        end
    end

    always_ff @(posedge auUserClk or negedge resetN) begin
        if (!resetN) begin
            mTdata     <= 32'd0;
            mTlast     <= 1'b0;
            mTvalid    <= 1'b0;
            pkt_seq    <= 16'd0;
            word_cnt   <= 16'd0;
            truncCount <= 16'd0;
        end else if (state == HEADER && o_free) begin
            mTdata   <= {HDR_TAG, 8'(grantIdx), pkt_seq};
            mTlast   <= 1'b0;
            mTvalid  <= 1'b1;
            pkt_seq  <= pkt_seq + 16'd1;
            word_cnt <= 16'd0;
        end else if (xfer) begin
            mTdata   <= grant_data;
            mTlast   <= grant_last || at_limit;
            mTvalid  <= 1'b1;
            word_cnt <= word_cnt + 16'd1;
            if (!grant_last && at_limit && truncCount != 16'hFFFF)
                truncCount <= truncCount + 16'd1;
        end else if (mTready) begin
            mTvalid <= 1'b0;
        end
    end

endmodule
